// File: rtl/lut_alu_arbiter_if.sv
// Requester and response bundle for lut_alu_arbiter. Flat per-requester
// vectors: requester i owns op[2i+:2], a/b[WIDTH*i +: WIDTH].
interface lut_alu_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, busy
    );
endinterface

// File: rtl/lut_alu_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/ADD ALU among NREQ
// requesters, with a LAT-deep globally stalled result pipeline.
module lut_alu_lane #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        unique case (op)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = a + b;
        endcase
    end
endmodule

module lut_alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int LAT   = 2
) (
    input  logic                clock,
    input  logic                reset,
    lut_alu_arbiter_if.slave    bus
);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [NREQ-1:0][WIDTH-1:0] lane_y;
    logic [IDW-1:0]             ptr;
    logic [IDW-1:0]             ptr_nxt;
    logic [IDW-1:0]             gnt;
    logic                       gnt_vld;
    logic [IDW:0]               sum;
    logic                       adv;
    logic                       accept;

    logic [LAT:1]               vld_pipe;
    logic [LAT:1][IDW-1:0]      id_pipe;
    logic [LAT:1][WIDTH-1:0]    y_pipe;

    // Every requester computes its result in parallel; the grant picks one.
    lut_alu_lane #(.WIDTH(WIDTH)) u_lane [NREQ-1:0] (
        .op (bus.req_op),
        .a  (bus.req_a),
        .b  (bus.req_b),
        .y  (lane_y)
    );

    // First valid requester at or after ptr, wrapping mod NREQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= NREQ_W) sum = sum - NREQ_W;
            if (!gnt_vld && bus.req_valid[sum[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt     = sum[IDW-1:0];
            end
        end
    end

    assign adv     = !vld_pipe[LAT] || bus.rsp_ready;
    // Gated by reset so req_ready drops the instant reset asserts.
    assign accept  = reset && gnt_vld && adv;
    assign ptr_nxt = (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[gnt] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            y_pipe   <= '0;
            ptr      <= '0;
        end else if (adv) begin
            vld_pipe[1] <= accept;
            id_pipe[1]  <= gnt;
            y_pipe[1]   <= lane_y[gnt];
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
                y_pipe[i]   <= y_pipe[i-1];
            end
            if (accept) ptr <= ptr_nxt;
        end
    end

    assign bus.rsp_valid = vld_pipe[LAT];
    assign bus.rsp_id    = id_pipe[LAT];
    assign bus.rsp_y     = y_pipe[LAT];
    assign bus.busy      = |vld_pipe;
endmodule

// File: tb/tb_lut_alu_arbiter.sv
// Scoreboard bench for lut_alu_arbiter (WIDTH=8, NREQ=4, LAT=2).
module tb_lut_alu_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   rsp_cnt = 0;

    logic [9:0] exp_q[$];
    logic [9:0] rsp_log[$];
    int         gnt_log[$];
    int         req_left[4];

    lut_alu_arbiter_if #(.WIDTH(8), .NREQ(4), .IDW(2)) bus ();

    lut_alu_arbiter #(.WIDTH(8), .NREQ(4), .IDW(2), .LAT(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    // Inputs only change at posedge+1, so negedge values are what the next edge commits.
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_q.push_back({2'(i), alu_ref(bus.req_op[2*i +: 2], bus.req_a[8*i +: 8], bus.req_b[8*i +: 8])});
                    gnt_log.push_back(i);
                    if (req_left[i] > 0) req_left[i]--;
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                logic [9:0] e;
                rsp_log.push_back({bus.rsp_id, bus.rsp_y});
                rsp_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: got id=%0d y=%02h, required no response", bus.rsp_id, bus.rsp_y);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.rsp_id, bus.rsp_y} !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got id=%0d y=%02h, required id=%0d y=%02h",
                                 bus.rsp_id, bus.rsp_y, e[9:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_op[2*i +: 2] = op;
        bus.req_a[8*i +: 8]  = a;
        bus.req_b[8*i +: 8]  = b;
        bus.req_valid[i]     = 1'b1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) req_left[i] = 0;
        @(posedge clock); #3;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clock); #3;
        reset = 1'b1;
    endtask

    // Drops each requester's valid once its quota of accepts has happened.
    task automatic run_until_done(input int bound);
        int c;
        for (c = 0; c < bound && bus.req_valid != 4'b0; c++) begin
            @(posedge clock); #1;
            for (int i = 0; i < 4; i++) if (req_left[i] == 0) bus.req_valid[i] = 1'b0;
        end
        checks++;
        if (bus.req_valid != 4'b0) begin
            errors++;
            $display("FAIL run_timeout: req_valid=%b still pending, required 0000", bus.req_valid);
        end
    endtask

    task automatic drain();
        int c;
        for (c = 0; c < 50; c++) begin
            if (exp_q.size() == 0 && !bus.busy) break;
            @(negedge clock);
        end
        checks++;
        if (exp_q.size() != 0 || bus.busy) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding busy=%b, required 0 and 0", exp_q.size(), bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 4'b1111;
        bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        #2;
        checks += 5;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
        if (bus.rsp_id !== 2'd0)    begin errors++; $display("FAIL reset_rsp_id: got %0d, required 0", bus.rsp_id); end
        if (bus.rsp_y !== 8'd0)     begin errors++; $display("FAIL reset_rsp_y: got %02h, required 00", bus.rsp_y); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b, required 0000", bus.req_ready); end
        bus.req_valid = '0;
        #1 reset = 1'b1;
    endtask

    task automatic test_single();
        int n0;
        n0 = rsp_cnt;
        @(posedge clock); #1;
        set_req(0, 2'b00, 8'd9, 8'd15);
        req_left[0] = 1;
        @(negedge clock);
        checks++;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b, required 0001", bus.req_ready); end
        @(posedge clock); #1;
        bus.req_valid[0] = 1'b0;
        checks += 2;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b, required 0", bus.rsp_valid); end
        if (bus.busy !== 1'b1)      begin errors++; $display("FAIL single_busy: got %b, required 1", bus.busy); end
        @(posedge clock); #1;
        checks += 3;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b, required 1", bus.rsp_valid); end
        if (bus.rsp_id !== 2'd0)    begin errors++; $display("FAIL single_rsp_id: got %0d, required 0", bus.rsp_id); end
        if (bus.rsp_y !== 8'd9)     begin errors++; $display("FAIL single_rsp_y: got %02h, required 09", bus.rsp_y); end
        @(posedge clock); #1;
        checks += 3;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b, required 0", bus.rsp_valid); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL single_busy_fall: got %b, required 0", bus.busy); end
        if (rsp_cnt - n0 != 1)      begin errors++; $display("FAIL single_count: got %0d responses, required 1", rsp_cnt - n0); end
    endtask

    task automatic test_ops();
        logic [1:0] ops[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] as[4]  = '{8'hF0, 8'hF0, 8'hF0, 8'hFF};
        logic [7:0] bs[4]  = '{8'h3C, 8'h3C, 8'h3C, 8'h02};
        logic [7:0] ys[4]  = '{8'h30, 8'hFC, 8'hCC, 8'h01};
        int c;
        rsp_log.delete();
        @(posedge clock); #1;
        for (int k = 0; k < 4; k++) begin
            set_req(1, ops[k], as[k], bs[k]);
            req_left[1] = 1;
            for (c = 0; c < 20 && req_left[1] != 0; c++) begin @(posedge clock); #1; end
            checks++;
            if (req_left[1] != 0) begin errors++; $display("FAIL ops_accept_timeout: op %0d not accepted, required accept", k); end
        end
        bus.req_valid[1] = 1'b0;
        drain();
        checks++;
        if (rsp_log.size() != 4) begin
            errors++; $display("FAIL ops_count: got %0d, required 4", rsp_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rsp_log[k] !== {2'd1, ys[k]}) begin
                    errors++; $display("FAIL ops_result_%0d: got id=%0d y=%02h, required id=1 y=%02h", k, rsp_log[k][9:8], rsp_log[k][7:0], ys[k]);
                end
            end
        end
    endtask

    task automatic load_all(input int quota);
        for (int i = 0; i < 4; i++) begin
            set_req(i, 2'(i), 8'(8'h5A + 8'(i * 17)), 8'(8'hC3 - 8'(i * 29)));
            req_left[i] = quota;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        gnt_log.delete(); rsp_log.delete();
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        load_all(3);
        run_until_done(40);
        drain();
        checks++;
        if (gnt_log.size() != 12 || rsp_log.size() != 12) begin
            errors++; $display("FAIL rr_count: got %0d grants %0d responses, required 12 and 12", gnt_log.size(), rsp_log.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks += 2;
                if (gnt_log[k] != k % 4) begin errors++; $display("FAIL rr_grant_%0d: got %0d, required %0d", k, gnt_log[k], k % 4); end
                if (int'(rsp_log[k][9:8]) != k % 4) begin errors++; $display("FAIL rr_rsp_id_%0d: got %0d, required %0d", k, rsp_log[k][9:8], k % 4); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] cap_id;
        logic [7:0] cap_y;
        int n0;
        do_reset();
        n0 = rsp_cnt;
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        load_all(3);
        repeat (4) begin @(posedge clock); #1; end
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        cap_id = bus.rsp_id;
        cap_y  = bus.rsp_y;
        checks++;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_full: rsp_valid got %b, required 1", bus.rsp_valid); end
        for (int s = 0; s < 5; s++) begin
            checks += 3;
            if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL bp_ready_%0d: got %b, required 0000", s, bus.req_ready); end
            if (bus.rsp_id !== cap_id)  begin errors++; $display("FAIL bp_id_%0d: got %0d, required %0d", s, bus.rsp_id, cap_id); end
            if (bus.rsp_y !== cap_y)    begin errors++; $display("FAIL bp_y_%0d: got %02h, required %02h", s, bus.rsp_y, cap_y); end
            @(negedge clock);
        end
        @(posedge clock); #1;
        bus.rsp_ready = 1'b1;
        run_until_done(60);
        drain();
        checks++;
        if (rsp_cnt - n0 != 12) begin errors++; $display("FAIL bp_total: got %0d responses, required 12", rsp_cnt - n0); end
    endtask

    task automatic test_two_req();
        do_reset();
        gnt_log.delete();
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        set_req(2, 2'd3, 8'h10, 8'h20); req_left[2] = 2;
        set_req(3, 2'd2, 8'hAA, 8'h0F); req_left[3] = 1;
        run_until_done(20);
        drain();
        checks++;
        if (gnt_log.size() != 3) begin
            errors++; $display("FAIL two_count: got %0d grants, required 3", gnt_log.size());
        end else begin
            checks += 3;
            if (gnt_log[0] != 2) begin errors++; $display("FAIL two_grant0: got %0d, required 2", gnt_log[0]); end
            if (gnt_log[1] != 3) begin errors++; $display("FAIL two_grant1: got %0d, required 3", gnt_log[1]); end
            if (gnt_log[2] != 2) begin errors++; $display("FAIL two_grant2: got %0d, required 2", gnt_log[2]); end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        set_req(1, 2'd1, 8'h11, 8'h22); req_left[1] = 1;
        set_req(2, 2'd2, 8'h33, 8'h44); req_left[2] = 1;
        @(posedge clock); #1;
        bus.req_valid[1] = 1'b0;
        @(posedge clock); #1;
        bus.req_valid[2] = 1'b0;
        set_req(0, 2'd3, 8'h80, 8'h81); req_left[0] = 1;
        #1;
        checks += 2;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight_rsp: got %b, required 1", bus.rsp_valid); end
        if (bus.busy !== 1'b1)      begin errors++; $display("FAIL mid_inflight_busy: got %b, required 1", bus.busy); end
        #1 reset = 1'b0;
        exp_q.delete();
        #1;
        checks += 3;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b, required 0", bus.rsp_valid); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b, required 0", bus.busy); end
        if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL mid_req_ready: got %b, required 0000", bus.req_ready); end
        @(posedge clock); #3;
        set_req(3, 2'd0, 8'h0F, 8'hFF); req_left[3] = 1;
        gnt_log.delete(); rsp_log.delete();
        reset = 1'b1;
        run_until_done(20);
        drain();
        checks++;
        if (gnt_log.size() != 2 || rsp_log.size() != 2) begin
            errors++; $display("FAIL mid_count: got %0d grants %0d responses, required 2 and 2", gnt_log.size(), rsp_log.size());
        end else begin
            checks += 3;
            if (gnt_log[0] != 0) begin errors++; $display("FAIL mid_first_grant: got %0d, required 0", gnt_log[0]); end
            if (rsp_log[0] !== {2'd0, 8'h01}) begin errors++; $display("FAIL mid_rsp0: got id=%0d y=%02h, required id=0 y=01", rsp_log[0][9:8], rsp_log[0][7:0]); end
            if (rsp_log[1] !== {2'd3, 8'h0F}) begin errors++; $display("FAIL mid_rsp1: got id=%0d y=%02h, required id=3 y=0f", rsp_log[1][9:8], rsp_log[1][7:0]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_left[i] = 0;
        test_reset();
        test_single();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_two_req();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lut_alu_arbiter.md
Name: lut_alu_arbiter

Overview:
- Shares one registered LUT-mapped ALU (AND/OR/XOR/ADD, WIDTH bits) among NREQ requesters.
- Round-robin arbitration, valid/ready handshake on every requester port, LAT-stage result pipeline, single response port tagged with requester ID, full backpressure.
- Sits between compiler-generated kernels and the shared lut_and/lut_alu-style datapath. Lets several i8 logic ops time-multiplex one LUT resource.

Parameters:
- WIDTH, 8, operand/result width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must equal ceil(log2(NREQ)), minimum 1.
- LAT, 2, ALU pipeline depth in register stages (1..4).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_op  in  2*NREQ  op per requester, slice [2i+1:2i]; 00 AND, 01 OR, 10 XOR, 11 ADD.
- req_a  in  WIDTH*NREQ  operand A per requester, slice [WIDTH*i +: WIDTH].
- req_b  in  WIDTH*NREQ  operand B per requester, same slicing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  index of requester that issued this result.
- rsp_y  out  WIDTH  result.
- busy  out  1  high while any pipeline stage holds a valid op.

Behaviour:
- Reset (reset==0, asynchronous):
  - All stage valid bits clear; round-robin pointer = 0.
  - rsp_valid=0, rsp_id=0, rsp_y=0, busy=0, req_ready=0.
  - Takes effect immediately, mid-operation included. In-flight ops are discarded and never reported.
- Pipeline:
  - LAT stages, each holding {valid, id, y}.
  - Stage 1 captures the computed result on accept. Stages 2..LAT are plain delay.
  - rsp_* come directly from stage LAT registers.
- Advance:
  - adv = !rsp_valid || rsp_ready. The whole pipeline shifts only when adv=1; otherwise it holds (global stall).
  - Bubbles are not compressed.
- Arbitration (combinational each cycle):
  - Search req_valid starting at pointer, ascending with wrap mod NREQ. The first set bit is the grant g.
  - req_ready[g] = adv; all other req_ready = 0. No valid requester means no grant and req_ready = 0.
- Accept:
  - Occurs when req_valid[g] && req_ready[g] at a rising edge.
  - Stage 1 loads valid=1, id=g, y=f(op_g, a_g, b_g).
  - Pointer becomes (g+1) mod NREQ. Pointer is unchanged on any cycle without an accept.
  - When adv=1 with no accept, stage 1 loads valid=0.
- Arithmetic:
  - ADD is modulo 2^WIDTH; carry is discarded.
  - Logic ops are bitwise. No signed interpretation.
- Latency:
  - An op accepted at edge E is presented with rsp_valid=1 after edge E+(LAT-1) when there is no stall.
  - LAT=1: the cycle immediately after accept.
  - Each stall cycle adds one cycle.
- Throughput: one accept per cycle when rsp_ready stays 1.
- Requester rules:
  - Must hold valid, op, a and b stable until accepted.
  - May deassert valid only after acceptance.
  - Block behaviour for violations is unspecified.
- Response rules: while rsp_valid=1 && rsp_ready=0, rsp_id and rsp_y hold stable.
- Simultaneous events:
  - A response handshake and a new accept in the same cycle are both legal. Stage LAT drains while stage 1 fills.
  - A requester granted while its valid drops cannot occur under the requester rules.
- Ordering: responses return in accept order.
- busy = OR of all stage valid bits.

Test Plan:
- LAT=2, only req0 valid, op=00, a=8'd9, b=8'd15, rsp_ready=1 -> req_ready[0] high the first cycle. Exactly one response rsp_id=0, rsp_y=8'd9 two cycles after accept. busy falls the cycle after the response handshake.
- Ops on req1 with a=8'hF0, b=8'h3C -> AND 8'h30, OR 8'hFC, XOR 8'hCC. ADD with a=8'hFF, b=8'h02 -> 8'h01 (wrap).
- All four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1,… one per cycle. rsp_id sequence matches grant order; no requester starved.
- Pipeline full, then rsp_ready=0 for 5 cycles -> req_ready all 0 and rsp_id/rsp_y constant throughout. Restore rsp_ready=1 -> no result lost or duplicated, order preserved.
- Only req2 and req3 valid, pointer at 0 -> req2 granted first, then req3, then req2 again.
- reset driven low between clock edges with 2 ops in flight -> rsp_valid, busy, req_ready fall immediately. After release, the first grant goes to req0 if valid, and the flushed ops never appear.
